load_store_unit: RTL and testbench

- Processor-side initiator for the byte-wide data memory.
- Accepts one load or store request per transaction, with RISC-V funct3 sizing.
- Serialises the request into 1/2/4/8 single-byte memory accesses, little-endian.
- For loads, assembles the bytes and returns a sign- or zero-extended 64-bit result; sits between the execute stage and the byte-addressed memory array.

---
 rtl/load_store_unit_if.sv | 34 +++
 rtl/load_store_unit.sv | 131 +++++++++++++
 tb/tb_load_store_unit.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Bundle of request, response and byte-memory signals around the load/store unit.
// The slave modport is the unit itself; the master modport is its surroundings
// (execute stage issuing requests plus the byte-addressed memory array).
interface load_store_unit_if #(
  parameter int ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [63:0]       resp_rdata;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              mem_re;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata, busy,
           mem_addr, mem_we, mem_re, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata, busy,
           mem_addr, mem_we, mem_re, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: splits one sized request into little-endian single-byte
// memory accesses and returns the sign/zero-extended load result.
module load_store_unit #(
  parameter int ADDR_W = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  load_store_unit_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t            state;
  state_t            next_state;
  logic              wr_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0]       wdata_q;
  logic [63:0]       asm_q;
  logic [63:0]       asm_next;
  logic [63:0]       rdata_q;
  logic [63:0]       ext_data;
  logic              err_q;
  logic [2:0]        cnt;
  logic [2:0]        last_idx;
  logic              illegal;

  // Index of the final byte: N-1 where N = 1 << size.
  assign last_idx = 3'((4'd1 << f3_q[1:0]) - 4'd1);

  // Stores have no unsigned forms; loads reject only the 111 encoding.
  assign illegal = bus.req_write ? bus.req_funct3[2] : (bus.req_funct3 == 3'b111);

  assign bus.mem_addr   = addr_q + ADDR_W'(cnt);
  assign bus.mem_wdata  = wdata_q[{cnt, 3'b000} +: 8];
  assign bus.resp_rdata = rdata_q;

  // Assembly register with the byte currently on the memory bus merged in.
  always_comb begin
    asm_next = asm_q;
    asm_next[{cnt, 3'b000} +: 8] = bus.mem_rdata;
  end

  // Sign- or zero-extend the assembled load to 64 bits.
  always_comb begin
    ext_data = 64'd0;
    case (f3_q)
      3'b000:  ext_data = {{56{asm_next[7]}},  asm_next[7:0]};
      3'b001:  ext_data = {{48{asm_next[15]}}, asm_next[15:0]};
      3'b010:  ext_data = {{32{asm_next[31]}}, asm_next[31:0]};
      3'b011:  ext_data = asm_next;
      3'b100:  ext_data = {56'd0, asm_next[7:0]};
      3'b101:  ext_data = {48'd0, asm_next[15:0]};
      3'b110:  ext_data = {32'd0, asm_next[31:0]};
      default: ext_data = 64'd0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next state and handshake/strobe outputs; strobes are masked by reset so a
  // write cannot land on the very edge that aborts the transaction.
  always_comb begin
    next_state     = state;
    bus.req_ready  = 1'b0;
    bus.busy       = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_re     = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) next_state = illegal ? DONE : XFER;
      end
      XFER: begin
        bus.busy   = 1'b1;
        bus.mem_we = wr_q & reset_n;
        bus.mem_re = ~wr_q & reset_n;
        if (cnt == last_idx) next_state = DONE;
      end
      DONE: begin
        bus.busy       = 1'b1;
        bus.resp_valid = 1'b1;
        bus.resp_err   = err_q;
        next_state     = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request capture, byte counter, load assembly and registered response data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 64'd0;
      asm_q   <= 64'd0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
      cnt     <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            wr_q    <= bus.req_write;
            f3_q    <= bus.req_funct3;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            err_q   <= illegal;
            asm_q   <= 64'd0;
            rdata_q <= 64'd0;
            cnt     <= 3'd0;
          end
        end
        XFER: begin
          if (!wr_q) asm_q <= asm_next;
          if (cnt == last_idx) rdata_q <= wr_q ? 64'd0 : ext_data;
          else                 cnt <= cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: byte memory model, cycle-level reference model
// with a single compare process, and directed transactions with literal results.
module tb_load_store_unit;
  localparam int ADDR_W = 64;

  logic clk = 1'b0;
  logic reset_n;
  logic init_req;

  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(ADDR_W)) bus ();

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] phys_mem  [0:31];
  logic [7:0] model_mem [0:31];

  // Initial memory image: bytes 0..7 fixed, the rest i ^ 0xCE (byte 12 = C2).
  function automatic logic [7:0] img(input int i);
    logic [7:0] first [0:7];
    first = '{8'hEB, 8'h12, 8'h78, 8'h4F, 8'h48, 8'hB6, 8'h45, 8'hFE};
    if (i < 8) return first[i];
    return 8'(i) ^ 8'hCE;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Byte memory: combinational read, write on posedge when strobed.
  assign bus.mem_rdata = phys_mem[bus.mem_addr[4:0]];

  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 32; i++) phys_mem[i] <= img(i);
    end else if (bus.mem_we) begin
      phys_mem[bus.mem_addr[4:0]] <= bus.mem_wdata;
    end
  end

  // Reference load result computed from the model's memory image.
  function automatic logic [63:0] model_load(input logic [63:0] addr, input logic [2:0] f3);
    int n;
    logic [63:0] v;
    logic [63:0] a;
    n = 1 << f3[1:0];
    v = 64'd0;
    for (int i = 0; i < n; i++) begin
      a = addr + 64'(i);
      v = v | (64'(model_mem[a[4:0]]) << (8 * i));
    end
    if (!f3[2] && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
    return v;
  endfunction

  bit          cmp_en = 0;
  bit          active = 0;
  bit          accept_next = 0;
  bit          rst_next = 0;
  int          k = 0;
  int          m_n = 0;
  logic        m_wr;
  logic        m_err;
  logic [2:0]  m_f3;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [63:0] m_exp;
  logic [63:0] hold_rdata = 64'd0;
  int          re_count = 0;
  int          we_count = 0;

  // Compare process: every cycle, check DUT outputs against the reference model.
  always @(negedge clk) begin
    bit idle_now;
    if (init_req) for (int i = 0; i < 32; i++) model_mem[i] = img(i);
    if (cmp_en) begin
      if (bus.mem_re) re_count++;
      if (bus.mem_we) we_count++;
      checkOutput("we_re_excl", 64'(bus.mem_we & bus.mem_re), 64'd0);
      if (rst_next) begin
        active = 0; hold_rdata = 64'd0; rst_next = 0; accept_next = 0;
      end else if (accept_next) begin
        active = 1; k = 1; hold_rdata = 64'd0; accept_next = 0;
        m_exp = (m_wr || m_err) ? 64'd0 : model_load(m_addr, m_f3);
      end else if (active) begin
        k++;
      end
      idle_now = !active;
      if (!reset_n) begin
        checkOutput("we_in_reset", 64'(bus.mem_we), 64'd0);
        checkOutput("re_in_reset", 64'(bus.mem_re), 64'd0);
      end else if (!active) begin
        checkOutput("idle_ready", 64'(bus.req_ready), 64'd1);
        checkOutput("idle_busy", 64'(bus.busy), 64'd0);
        checkOutput("idle_we", 64'(bus.mem_we), 64'd0);
        checkOutput("idle_re", 64'(bus.mem_re), 64'd0);
        checkOutput("idle_valid", 64'(bus.resp_valid), 64'd0);
        checkOutput("idle_err", 64'(bus.resp_err), 64'd0);
        checkOutput("idle_rdata", bus.resp_rdata, hold_rdata);
      end else if (m_err || k > m_n) begin
        checkOutput("done_valid", 64'(bus.resp_valid), 64'd1);
        checkOutput("done_err", 64'(bus.resp_err), 64'(m_err));
        checkOutput("done_busy", 64'(bus.busy), 64'd1);
        checkOutput("done_ready", 64'(bus.req_ready), 64'd0);
        checkOutput("done_we", 64'(bus.mem_we), 64'd0);
        checkOutput("done_re", 64'(bus.mem_re), 64'd0);
        checkOutput("done_rdata", bus.resp_rdata, m_exp);
        hold_rdata = m_exp;
        active = 0;
      end else begin
        checkOutput("xfer_valid", 64'(bus.resp_valid), 64'd0);
        checkOutput("xfer_busy", 64'(bus.busy), 64'd1);
        checkOutput("xfer_ready", 64'(bus.req_ready), 64'd0);
        checkOutput("xfer_we", 64'(bus.mem_we), 64'(m_wr));
        checkOutput("xfer_re", 64'(bus.mem_re), 64'(!m_wr));
        checkOutput("xfer_addr", bus.mem_addr, m_addr + 64'(k - 1));
        if (m_wr) begin
          checkOutput("xfer_wdata", 64'(bus.mem_wdata), 64'(m_wdata[8*(k-1) +: 8]));
          begin
            logic [63:0] a;
            a = m_addr + 64'(k - 1);
            model_mem[a[4:0]] = m_wdata[8*(k-1) +: 8];
          end
        end
      end
      if (!reset_n) begin
        rst_next = 1;
      end else if (idle_now && bus.req_valid) begin
        accept_next = 1;
        m_wr    = bus.req_write;
        m_f3    = bus.req_funct3;
        m_addr  = bus.req_addr;
        m_wdata = bus.req_wdata;
        m_err   = bus.req_write ? bus.req_funct3[2] : (bus.req_funct3 == 3'b111);
        m_n     = 1 << bus.req_funct3[1:0];
      end
    end
  end

  // Issue one request, wait for its response, and check literal expectations.
  task automatic applyStimulus(input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                               input logic [63:0] wdata, input logic [63:0] lit_rdata,
                               input logic lit_err, input int lit_lat,
                               input int lit_reads, input int lit_writes);
    int cyc;
    int re_base;
    int we_base;
    bit got;
    @(posedge clk); #1;
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    re_base = re_count;
    we_base = we_count;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.req_ready) got = 1;
    end
    if (!got) begin
      checkOutput("accept_timeout", 64'd0, 64'd1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    cyc = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.resp_valid) got = 1;
    end
    checkOutput("lit_latency", 64'(cyc), 64'(lit_lat));
    checkOutput("lit_rdata", bus.resp_rdata, lit_rdata);
    checkOutput("lit_err", 64'(bus.resp_err), 64'(lit_err));
    checkOutput("lit_reads", 64'(re_count - re_base), 64'(lit_reads));
    checkOutput("lit_writes", 64'(we_count - we_base), 64'(lit_writes));
  endtask

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence.
  initial begin
    reset_n        = 1'b0;
    init_req       = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 64'd0;
    bus.req_wdata  = 64'd0;
    repeat (2) @(posedge clk);
    #1 init_req = 1'b0;
    cmp_en = 1;
    @(posedge clk); #1;
    checkOutput("reset_ready", 64'(bus.req_ready), 64'd1);
    checkOutput("reset_rdata", bus.resp_rdata, 64'd0);
    checkOutput("reset_addr", bus.mem_addr, 64'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    applyStimulus(1'b0, 3'b011, 64'd0, 64'd0, 64'hFE45B6484F7812EB, 1'b0, 9, 8, 0);
    applyStimulus(1'b0, 3'b000, 64'd0, 64'd0, 64'hFFFFFFFFFFFFFFEB, 1'b0, 2, 1, 0);
    applyStimulus(1'b0, 3'b100, 64'd0, 64'd0, 64'h00000000000000EB, 1'b0, 2, 1, 0);
    applyStimulus(1'b0, 3'b000, 64'd1, 64'd0, 64'h0000000000000012, 1'b0, 2, 1, 0);
    applyStimulus(1'b0, 3'b010, 64'd0, 64'd0, 64'h000000004F7812EB, 1'b0, 5, 4, 0);
    applyStimulus(1'b0, 3'b110, 64'd4, 64'd0, 64'h00000000FE45B648, 1'b0, 5, 4, 0);
    applyStimulus(1'b0, 3'b001, 64'd4, 64'd0, 64'hFFFFFFFFFFFFB648, 1'b0, 3, 2, 0);
    applyStimulus(1'b0, 3'b101, 64'd4, 64'd0, 64'h000000000000B648, 1'b0, 3, 2, 0);
    applyStimulus(1'b0, 3'b001, 64'd2, 64'd0, 64'h0000000000004F78, 1'b0, 3, 2, 0);

    applyStimulus(1'b1, 3'b010, 64'd8, 64'h1122334455667788, 64'd0, 1'b0, 5, 0, 4);
    checkOutput("sw_byte8", 64'(phys_mem[8]), 64'h88);
    checkOutput("sw_byte9", 64'(phys_mem[9]), 64'h77);
    checkOutput("sw_byte10", 64'(phys_mem[10]), 64'h66);
    checkOutput("sw_byte11", 64'(phys_mem[11]), 64'h55);
    checkOutput("sw_byte12", 64'(phys_mem[12]), 64'hC2);

    applyStimulus(1'b1, 3'b100, 64'd8, 64'hFFFF, 64'd0, 1'b1, 1, 0, 0);
    applyStimulus(1'b0, 3'b111, 64'd0, 64'd0, 64'd0, 1'b1, 1, 0, 0);
    applyStimulus(1'b0, 3'b011, 64'd8, 64'd0, 64'hC1C0C3C255667788, 1'b0, 9, 8, 0);

    // Store aborted by reset after three bytes have been written.
    @(posedge clk); #1;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_funct3 = 3'b011;
    bus.req_addr   = 64'd16;
    bus.req_wdata  = 64'hA1A2A3A4A5A6A7A8;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_ready", 64'(bus.req_ready), 64'd1);
    checkOutput("rst_valid", 64'(bus.resp_valid), 64'd0);
    checkOutput("rst_byte16", 64'(phys_mem[16]), 64'hA8);
    checkOutput("rst_byte17", 64'(phys_mem[17]), 64'hA7);
    checkOutput("rst_byte18", 64'(phys_mem[18]), 64'hA6);
    checkOutput("rst_byte19", 64'(phys_mem[19]), 64'hDD);
    checkOutput("rst_byte23", 64'(phys_mem[23]), 64'hD9);
    repeat (3) @(posedge clk);

    // Doubleword store and load straddling the top of the address space.
    applyStimulus(1'b1, 3'b011, 64'hFFFFFFFFFFFFFFFE, 64'h0102030405060708, 64'd0, 1'b0, 9, 0, 8);
    checkOutput("wrap_byte_fe", 64'(phys_mem[30]), 64'h08);
    checkOutput("wrap_byte_00", 64'(phys_mem[0]), 64'h06);
    applyStimulus(1'b0, 3'b011, 64'hFFFFFFFFFFFFFFFE, 64'd0, 64'h0102030405060708, 1'b0, 9, 8, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 32; i++) checkOutput("mem_image", 64'(phys_mem[i]), 64'(model_mem[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
